// File: rtl/aux_input_conditioner.sv
// Synchronises and debounces the resume push-button and the slide switches on the board clock.
// Produces a debounced button level, a one-cycle press strobe, and a committed switch vector.
module aux_input_conditioner #(
  parameter int unsigned DebounceCnt = 500000,
  parameter int unsigned SwtBit      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resume_raw,
  input  logic [SwtBit-1:0] swt_raw,
  output logic              resume_level,
  output logic              resume_pulse,
  output logic [SwtBit-1:0] swt,
  output logic              swt_changed
);

  localparam int unsigned CntW = $clog2(DebounceCnt);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCnt - 1);

  typedef enum logic [1:0] {StIdle, StWaitHigh, StPressed, StWaitLow} btn_state_e;

  logic              resume_s1_q, resume_s2_q;
  logic [SwtBit-1:0] swt_s1_q, swt_s2_q;

  btn_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic              level_q, level_d;

  logic [SwtBit-1:0] cand_q, cand_d;
  logic [SwtBit-1:0] swt_q, swt_d;
  logic [CntW-1:0]   scnt_q, scnt_d;
  logic              changed_q, changed_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resume_s1_q <= 1'b0;
      resume_s2_q <= 1'b0;
      swt_s1_q    <= '0;
      swt_s2_q    <= '0;
    end else begin
      resume_s1_q <= resume_raw;
      resume_s2_q <= resume_s1_q;
      swt_s1_q    <= swt_raw;
      swt_s2_q    <= swt_s1_q;
    end
  end

  // Button FSM: a level is accepted only after DebounceCnt consecutive stable samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (resume_s2_q) begin
          state_d = StWaitHigh;
          cnt_d   = '0;
        end
      end
      StWaitHigh: begin
        if (!resume_s2_q) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d = StPressed;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (!resume_s2_q) begin
          state_d = StWaitLow;
          cnt_d   = '0;
        end
      end
      StWaitLow: begin
        if (resume_s2_q) begin
          state_d = StPressed;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    level_d = (state_d == StPressed) || (state_d == StWaitLow);
  end

  // Whole-vector debounce: any bit moving restarts the shared count.
  always_comb begin
    cand_d    = cand_q;
    scnt_d    = scnt_q;
    swt_d     = swt_q;
    changed_d = 1'b0;
    if (swt_s2_q != cand_q) begin
      cand_d = swt_s2_q;
      scnt_d = '0;
    end else if (scnt_q == CntMax) begin
      if (cand_q != swt_q) begin
        swt_d     = cand_q;
        changed_d = 1'b1;
      end
    end else begin
      scnt_d = scnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      level_q   <= 1'b0;
      cand_q    <= '0;
      swt_q     <= '0;
      scnt_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      level_q   <= level_d;
      cand_q    <= cand_d;
      swt_q     <= swt_d;
      scnt_q    <= scnt_d;
      changed_q <= changed_d;
    end
  end

  assign resume_level = level_q;
  assign resume_pulse = pulse_q;
  assign swt          = swt_q;
  assign swt_changed  = changed_q;

endmodule

// File: tb/tb_aux_input_conditioner.sv
// Directed-vector bench for aux_input_conditioner with DebounceCnt=4.
// Each table row is driven just after an edge and checked 1 time unit after the next edge.
module tb_aux_input_conditioner;

  localparam int unsigned Dc = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        resume_raw;
  logic [15:0] swt_raw;
  logic        resume_level;
  logic        resume_pulse;
  logic [15:0] swt;
  logic        swt_changed;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        r;
    logic [15:0] s;
    logic        exp_level;
    logic        exp_pulse;
    logic [15:0] exp_swt;
    logic        exp_changed;
  } vec_t;

  vec_t tv[$];

  aux_input_conditioner #(
    .DebounceCnt(Dc),
    .SwtBit     (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .resume_raw  (resume_raw),
    .swt_raw     (swt_raw),
    .resume_level(resume_level),
    .resume_pulse(resume_pulse),
    .swt         (swt),
    .swt_changed (swt_changed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic l, input logic p, input logic [15:0] w,
                           input logic c);
    check({tag, " resume_level"}, 32'(resume_level), 32'(l));
    check({tag, " resume_pulse"}, 32'(resume_pulse), 32'(p));
    check({tag, " swt"}, 32'(swt), 32'(w));
    check({tag, " swt_changed"}, 32'(swt_changed), 32'(c));
  endtask

  task automatic add(input logic r, input logic [15:0] s, input logic l, input logic p,
                     input logic [15:0] w, input logic c);
    vec_t v;
    v.r = r; v.s = s; v.exp_level = l; v.exp_pulse = p; v.exp_swt = w; v.exp_changed = c;
    tv.push_back(v);
  endtask

  initial begin
    // 1. idle inputs
    for (int i = 0; i < 20; i++) add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    // 2. clean press held 20 cycles, then release
    for (int i = 0; i < 20; i++) add(1'b1, 16'h0000, i >= 6, i == 6, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) add(1'b0, 16'h0000, i < 6, 1'b0, 16'h0000, 1'b0);
    // 3. bounce: 3 high, 1 low, 3 high, low
    for (int i = 0; i < 3; i++) add(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    // 4. switch commit, then bit 4 toggled away and restored inside the window
    for (int i = 0; i < 10; i++)
      add(1'b0, 16'h0013, 1'b0, 1'b0, (i >= 6) ? 16'h0013 : 16'h0000, i == 6);
    for (int i = 0; i < 2; i++) add(1'b0, 16'h0003, 1'b0, 1'b0, 16'h0013, 1'b0);
    for (int i = 0; i < 12; i++) add(1'b0, 16'h0013, 1'b0, 1'b0, 16'h0013, 1'b0);
    // 5. settle at 0x0003, then 0x8003 with a bit-0 glitch two cycles in
    for (int i = 0; i < 10; i++)
      add(1'b0, 16'h0003, 1'b0, 1'b0, (i >= 6) ? 16'h0003 : 16'h0013, i == 6);
    for (int i = 0; i < 15; i++)
      add(1'b0, (i == 2) ? 16'h8002 : 16'h8003, 1'b0, 1'b0,
          (i >= 9) ? 16'h8003 : 16'h0003, i == 9);

    rst_n      = 1'b0;
    resume_raw = 1'b0;
    swt_raw    = 16'h0000;
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < tv.size(); i++) begin
      resume_raw = tv[i].r;
      swt_raw    = tv[i].s;
      tick();
      check_all($sformatf("row%0d", i), tv[i].exp_level, tv[i].exp_pulse, tv[i].exp_swt,
                tv[i].exp_changed);
    end

    // 6. reset while the button is mid-qualification and the switches are pending
    resume_raw = 1'b1;
    swt_raw    = 16'h0005;
    for (int i = 0; i < 4; i++) tick();
    check_all("pre_rst", 1'b0, 1'b0, 16'h8003, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    tick();
    check_all("held_rst", 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // k counts post-release edges: k=0 is the first sampling edge
    for (int k = 0; k < 10; k++) begin
      tick();
      check_all($sformatf("post_rst%0d", k), k >= 6, k == 6, (k >= 6) ? 16'h0005 : 16'h0000,
                k == 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, required finished");
    $fatal(1);
  end

endmodule
